// File: rtl/udp_oe_tx_arbiter.sv
// Merges the ARP-reply source and NUM_CHAN IO-pipe TX channels onto one AXI-S stream toward the MAC.
// Optional per-channel packet / abort counters are built only when UDPOE_TX_ARB_STATS_EN is defined.
module udp_oe_tx_arbiter #(
    parameter int NUM_CHAN   = 2,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_CHAN-1:0]            ch_tvalid,
    input  logic [NUM_CHAN*DATA_WIDTH-1:0] ch_tdata,
    input  logic [NUM_CHAN*KEEP_WIDTH-1:0] ch_tkeep,
    input  logic [NUM_CHAN-1:0]            ch_tlast,
    output logic [NUM_CHAN-1:0]            ch_tready,
    input  logic                           arp_tvalid,
    input  logic [DATA_WIDTH-1:0]          arp_tdata,
    input  logic [KEEP_WIDTH-1:0]          arp_tkeep,
    input  logic                           arp_tlast,
    output logic                           arp_tready,
    output logic                           tx_tvalid,
    output logic [DATA_WIDTH-1:0]          tx_tdata,
    output logic [KEEP_WIDTH-1:0]          tx_tkeep,
    output logic                           tx_tlast,
    output logic                           tx_tuser,
    input  logic                           tx_tready,
    input  logic [NUM_CHAN-1:0]            chan_enable,
    input  logic [NUM_CHAN-1:0]            chan_reset,
    output logic                           busy,
    output logic [NUM_CHAN*32-1:0]         pkt_cnt,
    output logic [15:0]                    abort_cnt
);

    localparam int          CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int unsigned NC = NUM_CHAN;

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_ABORT} state_t;

    state_t                  state_q, state_d;
    logic                    gnt_arp_q, gnt_arp_d;
    logic [CW-1:0]           gnt_chan_q, gnt_chan_d;
    logic [CW-1:0]           last_chan_q, last_chan_d;
    logic                    last_arp_q, last_arp_d;
    logic                    fwd_q, fwd_d;
    logic                    tx_tvalid_q, tx_tvalid_d;
    logic [DATA_WIDTH-1:0]   tx_tdata_q, tx_tdata_d;
    logic [KEEP_WIDTH-1:0]   tx_tkeep_q, tx_tkeep_d;
    logic                    tx_tlast_q, tx_tlast_d;
    logic                    tx_tuser_q, tx_tuser_d;

    logic                    load_en;
    logic [NUM_CHAN-1:0]     ch_elig;
    logic                    rr_found;
    logic [CW-1:0]           rr_idx;
    logic [31:0]             idx;
    logic [CW-1:0]           idx_c;
    logic                    src_valid;
    logic [DATA_WIDTH-1:0]   src_data;
    logic [KEEP_WIDTH-1:0]   src_keep;
    logic                    src_last;
    logic                    gnt_rst;
    logic                    beat_load;
    logic                    abort_load;

    always_comb begin
        state_d     = state_q;
        gnt_arp_d   = gnt_arp_q;
        gnt_chan_d  = gnt_chan_q;
        last_chan_d = last_chan_q;
        last_arp_d  = last_arp_q;
        fwd_d       = fwd_q;
        tx_tvalid_d = tx_tvalid_q;
        tx_tdata_d  = tx_tdata_q;
        tx_tkeep_d  = tx_tkeep_q;
        tx_tlast_d  = tx_tlast_q;
        tx_tuser_d  = tx_tuser_q;
        arp_tready  = 1'b0;
        ch_tready   = '0;
        beat_load   = 1'b0;
        abort_load  = 1'b0;
        rr_found    = 1'b0;
        rr_idx      = '0;
        idx         = '0;
        idx_c       = '0;

        load_en = tx_tready | ~tx_tvalid_q;
        ch_elig = ch_tvalid & chan_enable & ~chan_reset;

        // Round-robin search starts just after the last channel that finished a packet.
        for (int unsigned k = 1; k <= NC; k++) begin
            idx   = (32'(last_chan_q) + k) % NC;
            idx_c = idx[CW-1:0];
            if (!rr_found && ch_elig[idx_c]) begin
                rr_found = 1'b1;
                rr_idx   = idx_c;
            end
        end

        src_valid = gnt_arp_q ? arp_tvalid : ch_tvalid[gnt_chan_q];
        src_data  = gnt_arp_q ? arp_tdata  : ch_tdata[int'(gnt_chan_q)*DATA_WIDTH +: DATA_WIDTH];
        src_keep  = gnt_arp_q ? arp_tkeep  : ch_tkeep[int'(gnt_chan_q)*KEEP_WIDTH +: KEEP_WIDTH];
        src_last  = gnt_arp_q ? arp_tlast  : ch_tlast[gnt_chan_q];
        gnt_rst   = ~gnt_arp_q & chan_reset[gnt_chan_q];

        if (load_en) begin
            tx_tvalid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                fwd_d = 1'b0;
                // ARP yields only when it won last time and a channel is waiting.
                if (arp_tvalid && !(last_arp_q && rr_found)) begin
                    gnt_arp_d  = 1'b1;
                    last_arp_d = 1'b1;
                    state_d    = ST_XFER;
                end else if (rr_found) begin
                    gnt_arp_d  = 1'b0;
                    gnt_chan_d = rr_idx;
                    last_arp_d = 1'b0;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                if (gnt_rst) begin
                    state_d = fwd_q ? ST_ABORT : ST_IDLE;
                end else begin
                    if (gnt_arp_q) begin
                        arp_tready = load_en;
                    end else begin
                        ch_tready[gnt_chan_q] = load_en;
                    end
                    if (src_valid && load_en) begin
                        beat_load   = 1'b1;
                        fwd_d       = 1'b1;
                        tx_tvalid_d = 1'b1;
                        tx_tdata_d  = src_data;
                        tx_tkeep_d  = src_keep;
                        tx_tlast_d  = src_last;
                        tx_tuser_d  = 1'b0;
                        if (src_last) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_ABORT: begin
                if (load_en) begin
                    abort_load  = 1'b1;
                    tx_tvalid_d = 1'b1;
                    tx_tdata_d  = '0;
                    tx_tkeep_d  = KEEP_WIDTH'(1);
                    tx_tlast_d  = 1'b1;
                    tx_tuser_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (((beat_load & src_last) | abort_load) & ~gnt_arp_q) begin
            last_chan_d = gnt_chan_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            gnt_arp_q   <= 1'b0;
            gnt_chan_q  <= '0;
            last_chan_q <= CW'(NUM_CHAN - 1);
            last_arp_q  <= 1'b0;
            fwd_q       <= 1'b0;
            tx_tvalid_q <= 1'b0;
            tx_tdata_q  <= '0;
            tx_tkeep_q  <= '0;
            tx_tlast_q  <= 1'b0;
            tx_tuser_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_arp_q   <= gnt_arp_d;
            gnt_chan_q  <= gnt_chan_d;
            last_chan_q <= last_chan_d;
            last_arp_q  <= last_arp_d;
            fwd_q       <= fwd_d;
            tx_tvalid_q <= tx_tvalid_d;
            tx_tdata_q  <= tx_tdata_d;
            tx_tkeep_q  <= tx_tkeep_d;
            tx_tlast_q  <= tx_tlast_d;
            tx_tuser_q  <= tx_tuser_d;
        end
    end

    assign tx_tvalid = tx_tvalid_q;
    assign tx_tdata  = tx_tdata_q;
    assign tx_tkeep  = tx_tkeep_q;
    assign tx_tlast  = tx_tlast_q;
    assign tx_tuser  = tx_tuser_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef UDPOE_TX_ARB_STATS_EN
    logic [NUM_CHAN-1:0][31:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0]               abort_cnt_q, abort_cnt_d;

    always_comb begin
        pkt_cnt_d   = pkt_cnt_q;
        abort_cnt_d = abort_cnt_q;
        if (beat_load && src_last && !gnt_arp_q) begin
            pkt_cnt_d[gnt_chan_q] = pkt_cnt_q[gnt_chan_q] + 32'd1;
        end
        // Abort count saturates; packet counts wrap.
        if (abort_load && (abort_cnt_q != '1)) begin
            abort_cnt_d = abort_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pkt_cnt_q   <= '0;
            abort_cnt_q <= '0;
        end else begin
            pkt_cnt_q   <= pkt_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign pkt_cnt   = pkt_cnt_q;
    assign abort_cnt = abort_cnt_q;
`else
    assign pkt_cnt   = '0;
    assign abort_cnt = '0;
`endif

endmodule

// File: doc/udp_oe_tx_arbiter.md
UDP_OE_TX_ARBITER -- requirements
Module: udp_oe_tx_arbiter

Interface
REQ-001 Parameter NUM_CHAN, default 2, number of IO-pipe TX channels (1..8).
REQ-002 Parameter DATA_WIDTH, default 64, AXI-S data width; KEEP_WIDTH = DATA_WIDTH/8.
REQ-003 clk  in  1  single clock; every port is synchronous to it.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 ch_tvalid/ch_tlast/ch_tready  in/in/out  NUM_CHAN each  per-channel AXI-S handshake; bit i is channel i.
REQ-006 ch_tdata/ch_tkeep  in  NUM_CHAN*DATA_WIDTH / NUM_CHAN*KEEP_WIDTH  flattened; channel i occupies slice i.
REQ-007 arp_tvalid, arp_tdata, arp_tkeep, arp_tlast, arp_tready  in/in/in/in/out  1/DATA_WIDTH/KEEP_WIDTH/1/1  ARP-reply source.
REQ-008 tx_tvalid, tx_tdata, tx_tkeep, tx_tlast, tx_tuser  out  1/DATA_WIDTH/KEEP_WIDTH/1/1  merged stream to the HSSI MAC; tx_tuser=1 marks an aborted frame.
REQ-009 tx_tready  in  1  MAC backpressure.
REQ-010 chan_enable, chan_reset  in  NUM_CHAN each  from the per-channel CSRs (misc ctrl and reset registers).
REQ-011 busy  out  1  high while the FSM is in XFER or ABORT.
REQ-012 pkt_cnt  out  NUM_CHAN*32  completed packets per channel; abort_cnt  out  16  aborted packets.

Function
REQ-013 FSM states: IDLE, XFER, ABORT.
REQ-014 IDLE: an eligible requester is one whose tvalid=1; a channel is additionally eligible only if chan_enable=1 and chan_reset=0. If any requester is eligible, the winner is registered and the FSM enters XFER on the next cycle.
REQ-015 Priority: ARP wins over channels, except when the previous grant was ARP and at least one channel is eligible; that channel then wins, so ARP is never granted twice in a row while a channel is waiting.
REQ-016 Channel choice is round-robin: search from last_chan+1, wrapping modulo NUM_CHAN; last_chan updates only when a channel packet completes or aborts.
REQ-017 The output is one register stage; load_en = tx_tready OR NOT tx_tvalid.
REQ-018 The granted source's tready equals load_en while in XFER; every other ready output is 0.
REQ-019 An input beat accepted in cycle N appears on tx_* in cycle N+1; tx_tuser=0 for normal beats.
REQ-020 XFER: on acceptance of a beat with tlast=1 the FSM returns to IDLE, which adds one bubble cycle between packets.
REQ-021 Output data is held stable while tx_tvalid=1 and tx_tready=0.
REQ-022 chan_reset of the granted channel during XFER, with zero beats forwarded: ch_tready drops to 0 and the FSM returns to IDLE with no output.
REQ-023 chan_reset of the granted channel during XFER, with at least one beat forwarded: the FSM enters ABORT and emits one beat with tdata=0, tkeep=1, tlast=1 and tuser=1 when load_en is high, then returns to IDLE.
REQ-024 chan_enable deasserted mid-packet has no effect on the packet in flight; it gates only new grants.
REQ-025 An ARP packet is never aborted.

Reset
REQ-026 With resetn=0 at a clk edge, the next state is: FSM=IDLE; tx_tvalid, tx_tlast and tx_tuser = 0; tx_tdata and tx_tkeep = 0; all readies 0; busy=0; last_chan=NUM_CHAN-1; last-grant-was-ARP flag=0; counters=0.
REQ-027 Reset mid-packet discards the partial frame with no abort beat; MAC-side framing recovery is the MAC's responsibility.

Configuration
REQ-028 Macro UDPOE_TX_ARB_STATS_EN:
- Defined: pkt_cnt[i] increments on each tlast=1 beat of channel i loaded into the output register, and wraps from 2^32-1 to 0. abort_cnt increments on each ABORT beat and saturates at 16'hFFFF.
- Undefined: pkt_cnt and abort_cnt are tied to 0 and no counter flops are built.

Verification
REQ-029 ch0 and ch1 both valid with 3-beat packets, tx_tready=1 -> order ch0, ch1, ch0, ch1; one bubble between packets; tx_tdata matches the inputs with 1-cycle latency.
REQ-030 arp_tvalid and ch0 valid together, ARP packets back-to-back -> order ARP, ch0, ARP, ch0; ARP is never granted twice in a row.
REQ-031 tx_tready toggled with 50% random pattern during a 5-beat packet -> no beat lost or duplicated; tx_* held stable while stalled.
REQ-032 chan_reset[1] pulsed after 2 of 4 beats forwarded -> abort beat emitted (tdata=0, tkeep=8'h01, tlast=1, tuser=1); abort_cnt=1 with UDPOE_TX_ARB_STATS_EN defined.
REQ-033 chan_enable[0]=0 while ch0 valid -> ch0 never granted and ch1 packets flow; clearing it mid-ch0-packet lets that packet complete.
REQ-034 pkt_cnt[0] preloaded via force to 32'hFFFF_FFFF, one ch0 packet sent -> pkt_cnt[0]=0; resetn=0 mid-packet -> all outputs match REQ-026 values on the next cycle.
